// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory stalls, branch redirects,
// wrong-path fetch discard and load-use bubbles; counts stall and flush cycles.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_src1_used,
  input  logic        id_src2_used,
  input  logic [2:0]  ex_dest,
  input  logic        ex_mem_read,
  input  logic        ex_regwrite,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  input  logic        redirect_ex,
  output logic        pc_load,
  output logic        pc_sel_redirect,
  output logic        load_if_id,
  output logic        clear_if_id,
  output logic        load_id_ex,
  output logic        clear_id_ex,
  output logic        load_ex_mem,
  output logic        clear_ex_mem,
  output logic        load_mem_wb,
  output logic        clear_mem_wb,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {RUN = 1'b0, DISCARD = 1'b1} state_t;

  state_t state, state_next;
  logic   stall_inc;
  logic   flush_inc;
  logic   load_use;

  assign load_use = ex_mem_read & ex_regwrite &
                    ((id_src1_used & (id_src1 == ex_dest)) |
                     (id_src2_used & (id_src2 == ex_dest)));

  // Priority resolution: reset > dmem stall > redirect > discard > imem stall > load-use
  always_comb begin
    pc_load         = 1'b1;
    pc_sel_redirect = 1'b0;
    load_if_id      = 1'b1;
    clear_if_id     = 1'b0;
    load_id_ex      = 1'b1;
    clear_id_ex     = 1'b0;
    load_ex_mem     = 1'b1;
    clear_ex_mem    = 1'b0;
    load_mem_wb     = 1'b1;
    clear_mem_wb    = 1'b0;
    state_next      = state;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;

    if (reset) begin
      pc_load      = 1'b0;
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      clear_ex_mem = 1'b1;
      clear_mem_wb = 1'b1;
      state_next   = RUN;
    end else if (dmem_stall) begin
      pc_load     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      stall_inc   = 1'b1;
    end else if (redirect_ex) begin
      pc_sel_redirect = 1'b1;
      clear_if_id     = 1'b1;
      clear_id_ex     = 1'b1;
      flush_inc       = 1'b1;
      // An outstanding fetch is wrong-path; its response must be dropped.
      state_next      = imem_stall ? DISCARD : RUN;
    end else if (state == DISCARD) begin
      pc_load     = 1'b0;
      clear_if_id = 1'b1;
      stall_inc   = 1'b1;
      state_next  = imem_stall ? DISCARD : RUN;
    end else if (imem_stall) begin
      pc_load     = 1'b0;
      clear_if_id = 1'b1;
      stall_inc   = 1'b1;
    end else if (load_use) begin
      pc_load     = 1'b0;
      load_if_id  = 1'b0;
      clear_id_ex = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  // State register and saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: expected control vector and
// counter values are queued with each stimulus step and checked mid-cycle.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_src1, id_src2, ex_dest;
  logic        id_src1_used, id_src2_used;
  logic        ex_mem_read, ex_regwrite;
  logic        imem_stall, dmem_stall, redirect_ex;
  logic        pc_load, pc_sel_redirect;
  logic        load_if_id, clear_if_id, load_id_ex, clear_id_ex;
  logic        load_ex_mem, clear_ex_mem, load_mem_wb, clear_mem_wb;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [9:0]  ctrl;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb[$];

  // {pc_load, pc_sel_redirect, load_if_id, clear_if_id, load_id_ex,
  //  clear_id_ex, load_ex_mem, clear_ex_mem, load_mem_wb, clear_mem_wb}
  localparam logic [9:0] C_DEF = 10'b10_10_10_10_10;
  localparam logic [9:0] C_RST = 10'b00_11_11_11_11;
  localparam logic [9:0] C_FRZ = 10'b00_00_00_00_00;
  localparam logic [9:0] C_RDR = 10'b11_11_11_10_10;
  localparam logic [9:0] C_BUB = 10'b00_11_10_10_10;
  localparam logic [9:0] C_LU  = 10'b00_00_11_10_10;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_regwrite(ex_regwrite),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .redirect_ex(redirect_ex),
    .pc_load(pc_load), .pc_sel_redirect(pc_sel_redirect),
    .load_if_id(load_if_id), .clear_if_id(clear_if_id),
    .load_id_ex(load_id_ex), .clear_id_ex(clear_id_ex),
    .load_ex_mem(load_ex_mem), .clear_ex_mem(clear_ex_mem),
    .load_mem_wb(load_mem_wb), .clear_mem_wb(clear_mem_wb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle_inputs();
    reset = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; redirect_ex = 1'b0;
    ex_mem_read = 1'b0; ex_regwrite = 1'b0; ex_dest = 3'd0;
    id_src1 = 3'd1; id_src2 = 3'd2; id_src1_used = 1'b0; id_src2_used = 1'b0;
  endtask

  task automatic check_one();
    exp_t e;
    logic [9:0] obs;
    e = sb.pop_front();
    obs = {pc_load, pc_sel_redirect, load_if_id, clear_if_id, load_id_ex,
           clear_id_ex, load_ex_mem, clear_ex_mem, load_mem_wb, clear_mem_wb};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed %b expected %b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (stall_cnt === e.scnt) else begin
      errors++;
      $error("FAIL %s stall_cnt observed %0h expected %0h", e.tag, stall_cnt, e.scnt);
    end
    checks++;
    assert (flush_cnt === e.fcnt) else begin
      errors++;
      $error("FAIL %s flush_cnt observed %0h expected %0h", e.tag, flush_cnt, e.fcnt);
    end
  endtask

  // Inputs are set by the caller after the preceding posedge; this queues the
  // expectation, samples mid-cycle, then advances through the next posedge.
  task automatic step(input string tag, input logic [9:0] ctrl,
                      input logic [15:0] scnt, input logic [15:0] fcnt);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.scnt = scnt; e.fcnt = fcnt;
    sb.push_back(e);
    @(negedge clk);
    check_one();
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    step("reset", C_RST, 16'd0, 16'd0);
    idle_inputs();
    step("idle", C_DEF, 16'd0, 16'd0);

    // Load-use on src1
    ex_mem_read = 1'b1; ex_regwrite = 1'b1; ex_dest = 3'd3;
    id_src1 = 3'd3; id_src1_used = 1'b1;
    step("loaduse", C_LU, 16'd0, 16'd0);
    idle_inputs();
    step("after_lu", C_DEF, 16'd1, 16'd0);

    // Matching registers but neither source used
    ex_mem_read = 1'b1; ex_regwrite = 1'b1; ex_dest = 3'd3;
    id_src1 = 3'd3; id_src2 = 3'd3;
    step("unused_src", C_DEF, 16'd1, 16'd0);

    // r0 is an ordinary register
    idle_inputs();
    ex_mem_read = 1'b1; ex_regwrite = 1'b1; ex_dest = 3'd0;
    id_src2 = 3'd0; id_src2_used = 1'b1;
    step("lu_r0", C_LU, 16'd1, 16'd0);
    ex_regwrite = 1'b0;
    step("lu_no_wr", C_DEF, 16'd2, 16'd0);
    idle_inputs();

    // Redirect with outstanding fetch, then discard 3 cycles
    redirect_ex = 1'b1; imem_stall = 1'b1;
    step("rdr_imem", C_RDR, 16'd2, 16'd0);
    redirect_ex = 1'b0;
    step("disc1", C_BUB, 16'd2, 16'd1);
    step("disc2", C_BUB, 16'd3, 16'd1);
    imem_stall = 1'b0;
    step("disc3", C_BUB, 16'd4, 16'd1);
    step("disc_done", C_DEF, 16'd5, 16'd1);

    // Plain redirect stays in RUN
    redirect_ex = 1'b1;
    step("rdr_run", C_RDR, 16'd5, 16'd1);
    redirect_ex = 1'b0;
    step("after_rdr", C_DEF, 16'd5, 16'd2);

    // dmem stall masks redirect until it clears
    dmem_stall = 1'b1; redirect_ex = 1'b1;
    step("frz1", C_FRZ, 16'd5, 16'd2);
    step("frz2", C_FRZ, 16'd6, 16'd2);
    dmem_stall = 1'b0;
    step("rdr_late", C_RDR, 16'd7, 16'd2);
    redirect_ex = 1'b0;
    step("after_late", C_DEF, 16'd7, 16'd3);

    // dmem stall holds DISCARD state
    redirect_ex = 1'b1; imem_stall = 1'b1;
    step("rdr_imem2", C_RDR, 16'd7, 16'd3);
    redirect_ex = 1'b0; dmem_stall = 1'b1;
    step("frz_disc", C_FRZ, 16'd7, 16'd4);
    dmem_stall = 1'b0; imem_stall = 1'b0;
    step("disc_held", C_BUB, 16'd8, 16'd4);
    step("run_again", C_DEF, 16'd9, 16'd4);

    // imem stall in RUN
    imem_stall = 1'b1;
    step("imem_run", C_BUB, 16'd9, 16'd4);
    imem_stall = 1'b0;
    step("after_imem", C_DEF, 16'd10, 16'd4);

    // Reset asserted mid-DISCARD
    redirect_ex = 1'b1; imem_stall = 1'b1;
    step("rdr_imem3", C_RDR, 16'd10, 16'd4);
    redirect_ex = 1'b0; reset = 1'b1;
    step("rst_disc", C_RST, 16'd10, 16'd5);
    idle_inputs();
    step("post_rst", C_DEF, 16'd0, 16'd0);

    // Long imem stall to reach saturation
    imem_stall = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    step("sat_fffe", C_BUB, 16'hFFFE, 16'd0);
    step("sat_ffff", C_BUB, 16'hFFFF, 16'd0);
    step("sat_hold", C_BUB, 16'hFFFF, 16'd0);
    imem_stall = 1'b0;
    step("sat_final", C_DEF, 16'hFFFF, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock, `clk`, and a synchronous active-high reset, `reset`.
REQ-002 Ports, listed as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- id_src1, id_src2  in  3 each  ID-stage source register numbers.
- id_src1_used, id_src2_used  in  1 each  the ID instruction reads that source.
- ex_dest  in  3  EX-stage destination register.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_regwrite  in  1  the EX instruction writes the register file.
- imem_stall  in  1  the fetch is outstanding; no instruction is valid this cycle.
- dmem_stall  in  1  the MEM-stage access is outstanding.
- redirect_ex  in  1  EX resolved a branch misprediction.
- pc_load  out  1  PC register load.
- pc_sel_redirect  out  1  PC mux selects the EX redirect target.
- load_if_id, clear_if_id  out  1 each  IF/ID pipeline register controls.
- load_id_ex, clear_id_ex  out  1 each  ID/EX pipeline register controls.
- load_ex_mem, clear_ex_mem  out  1 each  EX/MEM pipeline register controls.
- load_mem_wb, clear_mem_wb  out  1 each  MEM/WB pipeline register controls.
- stall_cnt  out  16  count of stall/bubble cycles.
- flush_cnt  out  16  count of redirects.
REQ-003 There are no parameters; all widths are fixed.

Function
REQ-004 All control outputs SHALL be combinational from the inputs and the FSM state; the counters SHALL be registered.
REQ-005 The FSM SHALL have two states: RUN and DISCARD.
REQ-006 Default (RUN, no event): all load_*=1, all clear_*=0, pc_load=1, pc_sel_redirect=0.
REQ-007 Events are resolved in fixed priority: dmem_stall > redirect_ex > DISCARD > imem_stall > load-use.
REQ-008 dmem_stall=1: all load_*=0, all clear_*=0, pc_load=0. The pipeline is fully frozen. The FSM state is held and redirect_ex is ignored that cycle; EX is frozen, so the redirect re-presents.
REQ-009 redirect_ex=1 with no dmem_stall:
- pc_load=1, pc_sel_redirect=1, clear_if_id=1, clear_id_ex=1.
- The EX/MEM and MEM/WB defaults are unchanged.
- flush_cnt increments.
REQ-010 A redirect while imem_stall=1 SHALL move the FSM to DISCARD, because the in-flight fetch is wrong-path. Otherwise the FSM goes to (or stays in) RUN.
REQ-011 DISCARD with no redirect: pc_load=0, clear_if_id=1, other stages at default.
- If imem_stall=0 (the wrong-path response arrives this cycle), it is squashed and the FSM returns to RUN next cycle.
- If imem_stall=1, the FSM stays in DISCARD.
REQ-012 imem_stall=1 in RUN: pc_load=0, clear_if_id=1 (bubble into ID); ID/EX and downstream advance.
REQ-013 Load-use condition, evaluated in RUN with imem_stall=0: ex_mem_read & ex_regwrite & ((id_src1_used & id_src1==ex_dest) | (id_src2_used & id_src2==ex_dest)).
REQ-014 On load-use: pc_load=0, load_if_id=0, clear_id_ex=1; EX/MEM and MEM/WB advance. The bubble lasts exactly one cycle per occurrence.
REQ-015 stall_cnt SHALL increment by 1 in any cycle where one of these holds: dmem_stall, imem_stall in RUN, DISCARD without redirect, or load-use.
REQ-016 flush_cnt SHALL increment by 1 per cycle of REQ-009.
REQ-017 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-018 Register r0 is not special; a match on register 0 stalls like any other register.

Reset
REQ-019 While reset=1:
- FSM goes to RUN; stall_cnt=0 and flush_cnt=0.
- All load_*=1 and all clear_*=1, so every pipeline register is flushed.
- pc_load=0, pc_sel_redirect=0.
REQ-020 Reset SHALL override every other input, including a reset asserted mid-DISCARD; the first cycle after reset uses RUN defaults.

Verification
REQ-021 Load-use: ex_mem_read=1, ex_regwrite=1, ex_dest=3, id_src1=3, id_src1_used=1 for one cycle -> pc_load=0, load_if_id=0, clear_id_ex=1; stall_cnt 0->1; next cycle at defaults.
REQ-022 Same as REQ-021 but id_src1_used=0 and id_src2=3 with id_src2_used=0 -> no stall, all outputs at default.
REQ-023 redirect_ex=1 with imem_stall=1, then imem_stall held for 2 cycles then 0 ->
- redirect cycle: pc_sel_redirect=1, clears on IF/ID and ID/EX;
- next 3 cycles in DISCARD: pc_load=0, clear_if_id=1;
- then RUN; flush_cnt=1, stall_cnt=3.
REQ-024 dmem_stall=1 together with redirect_ex=1 for 2 cycles, then dmem_stall=0 -> all loads 0 for 2 cycles, then the redirect executes on cycle 3; flush_cnt=1.
REQ-025 Preload stall_cnt=16'hFFFE via a continuous 65534-cycle imem_stall, hold 3 more cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-026 Assert reset during DISCARD -> next cycle all clears=1 and counters 0; after release, FSM is in RUN at defaults.
